// File: rtl/draw_track_bg.sv
// Track background drawer: bordered rectangle, two solid edge markers and LANES scrolling dashed dividers.
// Optional macro DRAW_TRACK_GRASS_EN adds RGB_GRASS for non-blanked pixels outside the rectangle.
module draw_track_bg #(
   parameter int          X_RECT    = 10,
   parameter int          Y_RECT    = 90,
   parameter int          WIDTH     = 780,
   parameter int          HEIGHT    = 500,
   parameter int          BORDER    = 5,
   parameter int          MARK_OFF  = 50,
   parameter int          MARK_W    = 2,
   parameter int          LANES     = 2,
   parameter int          DASH_LOG2 = 5,
   parameter logic [11:0] RGB_FG    = 12'hfff,
   parameter logic [11:0] RGB_DASH  = 12'hff0,
   parameter logic [11:0] RGB_BG    = 12'h000
`ifdef DRAW_TRACK_GRASS_EN
   ,
   parameter logic [11:0] RGB_GRASS = 12'h0a0
`endif
) (
   input  logic                 pclk,
   input  logic                 rst,
   input  logic [10:0]          hcount_in,
   input  logic [10:0]          vcount_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 hblnk_in,
   input  logic                 vblnk_in,
   input  logic                 scroll_en,
   input  logic [3:0]           speed_in,
   output logic [10:0]          hcount_out,
   output logic [10:0]          vcount_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 hblnk_out,
   output logic                 vblnk_out,
   output logic [11:0]          rgb_out,
   output logic [DASH_LOG2-1:0] scroll_off_out
);

   localparam logic [10:0] XR  = 11'(X_RECT);
   localparam logic [10:0] XE  = 11'(X_RECT + WIDTH);
   localparam logic [10:0] YR  = 11'(Y_RECT);
   localparam logic [10:0] YE  = 11'(Y_RECT + HEIGHT);
   localparam logic [10:0] XI0 = 11'(X_RECT + BORDER);
   localparam logic [10:0] XI1 = 11'(X_RECT + WIDTH - BORDER);
   localparam logic [10:0] YI0 = 11'(Y_RECT + BORDER);
   localparam logic [10:0] YI1 = 11'(Y_RECT + HEIGHT - BORDER);
   localparam logic [10:0] LM0 = 11'(X_RECT + MARK_OFF);
   localparam logic [10:0] LM1 = 11'(X_RECT + MARK_OFF + MARK_W);
   localparam logic [10:0] RM0 = 11'(X_RECT + WIDTH - MARK_OFF - MARK_W);
   localparam logic [10:0] RM1 = 11'(X_RECT + WIDTH - MARK_OFF);
   localparam int L_IN  = X_RECT + MARK_OFF + MARK_W;
   localparam int R_IN  = X_RECT + WIDTH - MARK_OFF - MARK_W;
   localparam int N_DIV = (LANES > 0) ? LANES : 1;

   logic [10:0]          hcount_q, vcount_q;
   logic                 hsync_q, vsync_q, hblnk_q, vblnk_q;
   logic [11:0]          rgb_q, rgb_d;
   logic [DASH_LOG2-1:0] offset_q, offset_d;
   logic                 vblnk_prev_q;
   logic                 tick;
   logic [DASH_LOG2-1:0] phase;
   logic                 dash_on;
   logic                 in_rect, in_inner, in_mark;
   logic [N_DIV-1:0]     div_hit;

   // Divider positions are fixed at elaboration; spare slots when LANES=0 never match.
   genvar gi;
   generate
      for (gi = 0; gi < N_DIV; gi++) begin : g_div
         if (gi < LANES) begin : g_on
            localparam logic [10:0] D0 = 11'(L_IN + ((gi + 1) * (R_IN - L_IN)) / (LANES + 1));
            localparam logic [10:0] D1 = 11'(L_IN + ((gi + 1) * (R_IN - L_IN)) / (LANES + 1) + MARK_W);
            assign div_hit[gi] = (hcount_in >= D0) && (hcount_in < D1);
         end else begin : g_off
            assign div_hit[gi] = 1'b0;
         end
      end
   endgenerate

   assign tick     = vblnk_in & ~vblnk_prev_q;
   assign offset_d = (tick && scroll_en) ? offset_q + DASH_LOG2'(speed_in) : offset_q;

   // Subtracting the offset makes a growing offset push the dashes down the screen.
   assign phase   = DASH_LOG2'(vcount_in - YR - 11'(offset_q));
   assign dash_on = ~phase[DASH_LOG2-1];

   assign in_rect  = (hcount_in >= XR) && (hcount_in < XE) && (vcount_in >= YR) && (vcount_in < YE);
   assign in_inner = (hcount_in >= XI0) && (hcount_in < XI1) && (vcount_in >= YI0) && (vcount_in < YI1);
   assign in_mark  = ((hcount_in >= LM0) && (hcount_in < LM1)) ||
                     ((hcount_in > RM0) && (hcount_in <= RM1));

   always_comb begin
      rgb_d = 12'h000;
      if (hblnk_in || vblnk_in) begin
         rgb_d = 12'h000;
      end else if (!in_rect) begin
`ifdef DRAW_TRACK_GRASS_EN
         rgb_d = RGB_GRASS;
`else
         rgb_d = 12'h000;
`endif
      end else if (!in_inner) begin
         rgb_d = RGB_FG;
      end else if (in_mark) begin
         rgb_d = RGB_FG;
      end else if ((|div_hit) && dash_on) begin
         rgb_d = RGB_DASH;
      end else begin
         rgb_d = RGB_BG;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_q     <= '0;
         vcount_q     <= '0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         rgb_q        <= '0;
         offset_q     <= '0;
         vblnk_prev_q <= 1'b0;
      end else begin
         hcount_q     <= hcount_in;
         vcount_q     <= vcount_in;
         hsync_q      <= hsync_in;
         vsync_q      <= vsync_in;
         hblnk_q      <= hblnk_in;
         vblnk_q      <= vblnk_in;
         rgb_q        <= rgb_d;
         offset_q     <= offset_d;
         vblnk_prev_q <= vblnk_in;
      end
   end

   assign hcount_out     = hcount_q;
   assign vcount_out     = vcount_q;
   assign hsync_out      = hsync_q;
   assign vsync_out      = vsync_q;
   assign hblnk_out      = hblnk_q;
   assign vblnk_out      = vblnk_q;
   assign rgb_out        = rgb_q;
   assign scroll_off_out = offset_q;

endmodule
